// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch stage. Owns the fetch PC, issues one
//            instruction-memory request at a time, buffers the returned
//            instruction for IF/ID and handles redirects/flushes, including
//            discarding an in-flight response.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h8000_0000,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    // instruction-memory request channel
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    // instruction-memory response channel (no back-pressure)
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    // flush / restart from later stages
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    // output buffer towards IF/ID
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    // REQ : nothing outstanding
    // WAIT: one request outstanding, its response will be kept
    // DROP: one request outstanding, its response will be discarded
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_out_valid;
    logic            w_out_valid_nxt;
    logic [XLEN-1:0] r_out_pc;
    logic [XLEN-1:0] w_out_pc_nxt;
    logic [31:0]     r_out_instr;
    logic [31:0]     w_out_instr_nxt;
    logic            w_req_hs;
    logic [XLEN-1:0] w_redirect_aligned;

    // Requests only go out when the buffer is (or is about to be) empty, so a
    // returning response always has room to land.
    assign imem_req_valid     = (r_state == S_REQ) && !rst && (!r_out_valid || out_ready);
    assign imem_req_addr      = r_pc;
    assign w_req_hs           = imem_req_valid && imem_req_ready;
    assign w_redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_instr = r_out_instr;

    // Next-state, PC and output-buffer computation; a redirect overrides the
    // normal updates at the end.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_out_valid_nxt = r_out_valid;
        w_out_pc_nxt    = r_out_pc;
        w_out_instr_nxt = r_out_instr;

        // drain; a refill below cannot coincide with this by construction
        if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        case (r_state)
            S_REQ: begin
                if (w_req_hs) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_out_instr_nxt = imem_rsp_data;
                    w_out_pc_nxt    = r_pc;
                    w_out_valid_nxt = 1'b1;
                    w_pc_nxt        = r_pc + c_PC_STEP;
                    w_state_nxt     = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            w_pc_nxt        = w_redirect_aligned;
            w_out_valid_nxt = 1'b0;
            w_out_instr_nxt = NOP_INSTR;
            w_out_pc_nxt    = r_out_pc;
            case (r_state)
                // an accepted old-address request must have its response dropped
                S_REQ:   w_state_nxt = w_req_hs ? S_DROP : S_REQ;
                S_WAIT:  w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                S_DROP:  w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // State, PC and output-buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_instr <= NOP_INSTR;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_out_instr <= w_out_instr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Randomized self-checking bench for ifu_fetch. A transaction-level
//            model tracks the next fetch address, the single outstanding
//            request (and whether a redirect has killed it), and the IF/ID
//            buffer contents. Memory data is a function of the address so a
//            wrongly kept response shows up as a data/PC mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    ifu_fetch #(
        .XLEN      (XLEN),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // single comparison point for the whole bench
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // instruction word stored at a given address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F13;
    endfunction

    // ---------------- reference model state ----------------
    logic [31:0] m_fetch;      // address of the next request to issue
    logic        m_out;        // a request is outstanding
    logic        m_kill;       // the outstanding request's response is unwanted
    logic [31:0] m_out_addr;
    logic        m_buf_v;
    logic [31:0] m_buf_pc;
    logic [31:0] m_buf_instr;
    // memory side
    int          mem_cnt;

    task automatic model_reset();
        m_fetch     = RESET_PC;
        m_out       = 1'b0;
        m_kill      = 1'b0;
        m_out_addr  = '0;
        m_buf_v     = 1'b0;
        m_buf_pc    = '0;
        m_buf_instr = NOP_INSTR;
        mem_cnt     = 0;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(5))
            0:       t = 32'h8000_0102;
            1:       t = 32'hFFFF_FFFC;
            2:       t = 32'hFFFF_FFF7;
            3:       t = 32'h8000_0000 + ($urandom_range(63) << 2);
            default: t = $urandom;
        endcase
        return t;
    endfunction

    // one cycle: check outputs, drive inputs, check request, advance model
    task automatic run_cycle(input int p_rst, input int p_redir, input int p_oready,
                             input int p_qready, input int max_lat);
        logic        exp_req_v;
        logic        hs;
        logic        rsp;
        logic [31:0] tgt;

        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_buf_v});
        chk("out_pc",    out_pc,    m_buf_pc);
        chk("out_instr", out_instr, m_buf_instr);

        rsp            = m_out && (mem_cnt == 0);
        tgt            = pick_target();
        rst            = ($urandom_range(99) < p_rst);
        redirect_valid = ($urandom_range(99) < p_redir);
        redirect_pc    = tgt;
        out_ready      = ($urandom_range(99) < p_oready);
        imem_req_ready = ($urandom_range(99) < p_qready);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(m_out_addr) : $urandom;
        #1;

        exp_req_v = !rst && !m_out && (!m_buf_v || out_ready);
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req_v});
        if (exp_req_v) chk("req_addr", imem_req_addr, m_fetch);
        hs = exp_req_v && imem_req_ready;

        if (rst) begin
            model_reset();
        end else begin
            if (m_buf_v && out_ready) m_buf_v = 1'b0;
            if (rsp) begin
                m_out = 1'b0;
                if (!m_kill && !redirect_valid) begin
                    m_buf_v     = 1'b1;
                    m_buf_pc    = m_out_addr;
                    m_buf_instr = mem_word(m_out_addr);
                    m_fetch     = m_out_addr + 32'd4;
                end
            end else if (m_out) begin
                mem_cnt--;
            end
            if (hs) begin
                m_out      = 1'b1;
                m_kill     = 1'b0;
                m_out_addr = m_fetch;
                mem_cnt    = $urandom_range(max_lat - 1);
            end
            if (redirect_valid) begin
                m_fetch     = {tgt[31:2], 2'b00};
                m_buf_v     = 1'b0;
                m_buf_instr = NOP_INSTR;
                if (m_out) m_kill = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        // first checked cycle releases reset (p_rst=0)
        // phase 1: fast memory, ready consumer, no redirects (throughput path)
        for (int i = 0; i < 200; i++) run_cycle(0, 0, 100, 100, 1);
        // phase 2: back-pressure from IF/ID and memory
        for (int i = 0; i < 1500; i++) run_cycle(0, 0, 40, 60, 3);
        // phase 3: frequent redirects with variable latency
        for (int i = 0; i < 3000; i++) run_cycle(0, 20, 70, 70, 4);
        // phase 4: heavy redirects, fast memory (same-cycle redirect/response/handshake)
        for (int i = 0; i < 3000; i++) run_cycle(0, 45, 80, 90, 1);
        // phase 5: everything including occasional reset mid-transaction
        for (int i = 0; i < 3000; i++) run_cycle(3, 15, 60, 70, 4);
        // final quiet stretch so the design settles after any reset
        for (int i = 0; i < 100; i++) run_cycle(0, 0, 100, 100, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage of the 5-stage NPC pipeline; sits directly upstream of the IF/ID pipeline register. Owns the fetch PC and issues one instruction-memory request at a time over a valid/ready request channel with a variable-latency response. Each returned instruction is held in a one-entry output buffer presented to IF/ID with valid/ready. Handles redirects (branch/jump/exception flush) from later stages, including discarding an in-flight response.

Parameters:
XLEN, 32, width of PC and memory address.
RESET_PC, 32'h8000_0000, first fetch address after reset.
NOP_INSTR, 32'h0000_0013, value of out_instr at reset and after a flush.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_req_addr  output  XLEN  fetch address; always equals the current pc.
imem_rsp_valid  input  1  response valid; exactly one per accepted request, arriving at least 1 cycle after the handshake; no back-pressure.
imem_rsp_data  input  32  instruction word.
redirect_valid  input  1  flush and restart fetch at redirect_pc.
redirect_pc  input  XLEN  new fetch target; bits [1:0] ignored and forced to 0.
out_valid  output  1  output buffer holds a valid instruction.
out_ready  input  1  IF/ID accepts the buffer this cycle.
out_pc  output  XLEN  address of the buffered instruction.
out_instr  output  32  buffered instruction.

Behaviour:
- Reset: pc=RESET_PC, state=REQ, out_valid=0, out_pc=0, out_instr=NOP_INSTR. imem_req_valid is 0 while rst=1. rst has priority over every other input.
- States:
  - REQ: no request outstanding.
  - WAIT: one request outstanding; its response will be kept.
  - DROP: one request outstanding; its response will be discarded.
- Maximum one outstanding request.
- imem_req_valid = (state==REQ) && !rst && (!out_valid || out_ready).
  - Guarantees the buffer is empty when the response lands.
  - Once asserted it stays asserted until the handshake, except that a redirect may change imem_req_addr before acceptance.
- REQ: handshake (valid && ready) -> WAIT. Otherwise stay in REQ.
- WAIT: on imem_rsp_valid:
  - out_instr<=imem_rsp_data, out_pc<=pc, out_valid<=1;
  - pc<=pc+4 (mod 2^XLEN, wraps to 0);
  - state -> REQ.
- DROP: on imem_rsp_valid, discard the data and go to REQ; pc is unchanged (already holds the redirect target).
- Output buffer: out_valid clears on out_valid && out_ready unless refilled the same cycle. A refill cannot coincide with a drain by construction. out_pc and out_instr stay stable while out_valid && !out_ready.
- Redirect (redirect_valid=1, rst=0) overrides normal updates:
  - pc<=redirect_pc & ~3;
  - out_valid<=0, out_instr<=NOP_INSTR, out_pc unchanged.
  - Next state by current condition:
    - REQ, no handshake this cycle -> REQ; the request is retried at the new pc.
    - REQ, handshake this cycle (old address accepted) -> DROP.
    - WAIT, no response this cycle -> DROP.
    - WAIT, response this cycle -> response discarded, pc not incremented, state -> REQ.
    - DROP, no response -> DROP, pc updated. DROP, response -> REQ.
- Throughput: with 1-cycle memory and out_ready held 1, one instruction every 2 cycles. First request occurs in the cycle after rst deasserts.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning 0x00000093, out_ready=1 -> first handshake with addr 0x80000000; out_valid=1 with out_pc=0x80000000 two cycles after the handshake; next request at 0x80000004.
- Hold out_ready=0 after the first fill -> out_pc/out_instr stable, imem_req_valid=0; release out_ready -> request at 0x80000004 issued in that same cycle.
- Redirect to 0x80000102 while in WAIT, response arriving 3 cycles later with 0xDEADBEEF -> 0xDEADBEEF never appears on out_*; next request addr 0x80000100; out_valid cleared the cycle after the redirect.
- Redirect in the same cycle as the response -> response discarded, next request at the redirect target; same-cycle redirect plus request handshake -> DROP entered and that response discarded.
- pc=0xFFFFFFFC (XLEN=32), response returns -> out_pc=0xFFFFFFFC, next request addr 0x00000000.
- rst asserted while in WAIT with a response pending -> next cycle out_valid=0, imem_req_valid=0; after rst drops, fetch restarts at RESET_PC.
